jtag_dr_chain: RTL and testbench

- Downstream consumer of the TAP controller state; sits between the TAP FSM and the TDO pin.
- Owns the instruction register (IR) and the data registers it selects: IDCODE (32-bit), BYPASS (1-bit) and a USER scratch register.
- Performs capture/shift/update for IR and DR, driving TDO from the selected register LSB.
- Exposes the decoded instruction and an update strobe for the USER register to core logic in the tck domain.

---
 rtl/jtag_pkg.sv | 16 +
 rtl/jtag_shift_reg.sv | 25 ++
 rtl/jtag_dr_chain.sv | 85 ++++++++
 tb/tb_jtag_dr_chain.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction codes and helpers shared by the TAP FSM and DR chain.
package jtag_pkg;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR_SCAN, CAPTURE_DR,
        SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_e;
    localparam int IR_WIDTH_DEFAULT = 4;
    localparam logic [3:0] INSN_ABORT  = 4'b1000;
    localparam logic [3:0] INSN_IDCODE = 4'b1110;
    localparam logic [3:0] INSN_BYPASS = 4'b1111;
    localparam logic [3:0] INSN_USER   = 4'b0010;
    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (&c) ? c : c + 6'd1;
    endfunction
endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: capture/shift register; serial data enters at the one-hot tap_sel position,
// so the effective chain length is chosen at run time while bits above it just drain away.
module jtag_shift_reg #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = WIDTH
) (
    input  logic                 tck,
    input  logic                 trst_n,
    input  logic                 capture,
    input  logic                 shift,
    input  logic                 sdi,
    input  logic [WIDTH-1:0]     capture_value,
    input  logic [WIDTH-1:0]     tap_sel,
    output logic [OUT_WIDTH-1:0] q
);
    logic [WIDTH-1:0] data;

    always_ff @(posedge tck) begin
        if (!trst_n) data <= '0;
        else if (capture) data <= capture_value;
        else if (shift) data <= ({1'b0, data[WIDTH-1:1]} & ~tap_sel) | ({WIDTH{sdi}} & tap_sel);
    end

    assign q = data[OUT_WIDTH-1:0];
endmodule

// File: rtl/jtag_dr_chain.sv
// jtag_dr_chain: IR plus IDCODE/BYPASS/USER data registers driven by the TAP state,
// muxing the selected register LSB onto TDO.
module jtag_dr_chain
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = IR_WIDTH_DEFAULT,
    parameter logic [31:0]           IDCODE_VALUE = 32'h000FAF01,
    parameter int                    USER_WIDTH   = 8,
    parameter logic [USER_WIDTH-1:0] USER_RESET   = '0
) (
    input  logic                  tck,
    input  logic                  trst_n,
    input  logic                  enable,
    input  logic [3:0]            tap_state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [IR_WIDTH-1:0]   ir_value,
    output logic [USER_WIDTH-1:0] user_q,
    output logic                  user_update,
    output logic [5:0]            shift_count
);
    localparam int DR_WIDTH = USER_WIDTH > 32 ? USER_WIDTH : 32;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSN_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(INSN_USER);

    tap_state_e            st;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic [USER_WIDTH-1:0] dr_low;
    logic [DR_WIDTH-1:0]   dr_capture;
    logic [DR_WIDTH-1:0]   dr_tap;

    assign st = tap_state_e'(tap_state);

    // Anything that is not IDCODE or USER behaves as a 1-bit bypass register.
    always_comb begin
        dr_capture = ir_value == IR_IDCODE ? DR_WIDTH'(IDCODE_VALUE) :
                     ir_value == IR_USER   ? DR_WIDTH'(user_q) : '0;
        dr_tap     = ir_value == IR_IDCODE ? DR_WIDTH'(1) << 31 :
                     ir_value == IR_USER   ? DR_WIDTH'(1) << (USER_WIDTH - 1) : DR_WIDTH'(1);
    end

    jtag_shift_reg #(.WIDTH(IR_WIDTH), .OUT_WIDTH(IR_WIDTH)) u_ir (
        .tck           (tck),
        .trst_n        (trst_n),
        .capture       (enable && st == CAPTURE_IR),
        .shift         (enable && st == SHIFT_IR),
        .sdi           (tdi),
        .capture_value (IR_WIDTH'(2'b01)),
        .tap_sel       ({1'b1, {(IR_WIDTH-1){1'b0}}}),
        .q             (ir_shift)
    );

    jtag_shift_reg #(.WIDTH(DR_WIDTH), .OUT_WIDTH(USER_WIDTH)) u_dr (
        .tck           (tck),
        .trst_n        (trst_n),
        .capture       (enable && st == CAPTURE_DR),
        .shift         (enable && st == SHIFT_DR),
        .sdi           (tdi),
        .capture_value (dr_capture),
        .tap_sel       (dr_tap),
        .q             (dr_low)
    );

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_value    <= IR_IDCODE;
            user_q      <= USER_RESET;
            user_update <= 1'b0;
            shift_count <= '0;
        end else begin
            user_update <= enable && st == UPDATE_DR && ir_value == IR_USER;
            if (enable) begin
                if (st == TEST_LOGIC_RESET) ir_value <= IR_IDCODE;
                else if (st == UPDATE_IR) ir_value <= ir_shift;
                if (st inside {TEST_LOGIC_RESET, CAPTURE_IR, CAPTURE_DR}) shift_count <= '0;
                else if (st inside {SHIFT_IR, SHIFT_DR}) shift_count <= sat_inc(shift_count);
                if (st == UPDATE_DR && ir_value == IR_USER) user_q <= dr_low;
            end
        end
    end

    assign tdo    = st == SHIFT_IR ? ir_shift[0] : st == SHIFT_DR ? dr_low[0] : 1'b0;
    assign tdo_oe = st == SHIFT_IR || st == SHIFT_DR;
endmodule

// File: tb/tb_jtag_dr_chain.sv
// tb_jtag_dr_chain: directed scans plus a random legal TAP walk, checked every cycle
// against a queue-based model of the scan chains.
module tb_jtag_dr_chain;
    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SDR = 4'd2, CDR = 4'd3, SHDR = 4'd4, E1D = 4'd5,
                           PD = 4'd6, E2D = 4'd7, UDR = 4'd8, SIR = 4'd9, CIR = 4'd10, SHIR = 4'd11,
                           E1I = 4'd12, PI = 4'd13, E2I = 4'd14, UIR = 4'd15;
    localparam logic [31:0] IDC = 32'h000FAF01;

    logic tck = 1'b0, trst_n = 1'b0, enable = 1'b0, tdi = 1'b0;
    logic [3:0] tap_state = TLR;
    logic tdo, tdo_oe, user_update;
    logic [3:0] ir_value;
    logic [7:0] user_q;
    logic [5:0] shift_count;

    always #5 tck = ~tck;

    jtag_dr_chain dut (
        .tck(tck), .trst_n(trst_n), .enable(enable), .tap_state(tap_state), .tdi(tdi),
        .tdo(tdo), .tdo_oe(tdo_oe), .ir_value(ir_value), .user_q(user_q),
        .user_update(user_update), .shift_count(shift_count)
    );

    int checks = 0, errors = 0;
    bit irq[$], drq[$];
    logic [3:0] m_ir = 4'hE;
    logic [7:0] m_user = 8'h00;
    logic m_upd = 1'b0;
    int m_cnt = 0;
    bit live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q2v(input bit q[$]);
        logic [31:0] v = '0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic compare();
        logic exp_tdo;
        exp_tdo = tap_state == SHIR ? irq[0] : tap_state == SHDR ? drq[0] : 1'b0;
        chk("tdo", {31'b0, tdo}, {31'b0, exp_tdo});
        chk("tdo_oe", {31'b0, tdo_oe}, {31'b0, tap_state == SHIR || tap_state == SHDR});
        chk("ir_value", {28'b0, ir_value}, {28'b0, m_ir});
        chk("user_q", {24'b0, user_q}, {24'b0, m_user});
        chk("user_update", {31'b0, user_update}, {31'b0, m_upd});
        chk("shift_count", {26'b0, shift_count}, m_cnt);
    endtask

    task automatic model_edge();
        int len;
        logic [31:0] val;
        if (!trst_n) begin
            m_ir = 4'hE; m_user = 8'h00; m_upd = 1'b0; m_cnt = 0;
            irq = {1'b0, 1'b0, 1'b0, 1'b0};
            drq.delete();
            for (int i = 0; i < 32; i++) drq.push_back(1'b0);
        end else if (!enable) begin
            m_upd = 1'b0;
        end else begin
            m_upd = 1'b0;
            case (tap_state)
                TLR: begin m_ir = 4'hE; m_cnt = 0; end
                CIR: begin irq = {1'b1, 1'b0, 1'b0, 1'b0}; m_cnt = 0; end
                SHIR: begin
                    void'(irq.pop_front()); irq.push_back(tdi);
                    m_cnt = m_cnt < 63 ? m_cnt + 1 : 63;
                end
                UIR: m_ir = q2v(irq)[3:0];
                CDR: begin
                    len = m_ir == 4'hE ? 32 : m_ir == 4'h2 ? 8 : 1;
                    val = m_ir == 4'hE ? IDC : m_ir == 4'h2 ? {24'b0, m_user} : 32'b0;
                    drq.delete();
                    for (int i = 0; i < len; i++) drq.push_back(val[i]);
                    m_cnt = 0;
                end
                SHDR: begin
                    void'(drq.pop_front()); drq.push_back(tdi);
                    m_cnt = m_cnt < 63 ? m_cnt + 1 : 63;
                end
                UDR: if (m_ir == 4'h2) begin m_user = q2v(drq)[7:0]; m_upd = 1'b1; end
                default: ;
            endcase
        end
        live = 1'b1;
    endtask

    task automatic cyc(input logic en, input logic rst_n, input logic tdi_v, output logic t);
        @(negedge tck);
        enable = en; trst_n = rst_n; tdi = tdi_v;
        #1;
        t = tdo;
        if (live) compare();
        @(posedge tck);
        model_edge();
        #1;
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic tms);
        case (s)
            TLR:  return tms ? TLR : RTI;
            RTI:  return tms ? SDR : RTI;
            SDR:  return tms ? SIR : CDR;
            CDR:  return tms ? E1D : SHDR;
            SHDR: return tms ? E1D : SHDR;
            E1D:  return tms ? UDR : PD;
            PD:   return tms ? E2D : PD;
            E2D:  return tms ? UDR : SHDR;
            UDR:  return tms ? SDR : RTI;
            SIR:  return tms ? TLR : CIR;
            CIR:  return tms ? E1I : SHIR;
            SHIR: return tms ? E1I : SHIR;
            E1I:  return tms ? UIR : PI;
            PI:   return tms ? E2I : PI;
            E2I:  return tms ? UIR : SHIR;
            default: return tms ? SDR : RTI;
        endcase
    endfunction

    task automatic step(input logic tms, input logic tdi_v, input logic en, input logic rst_n, output logic t);
        cyc(en, rst_n, tdi_v, t);
        if (!rst_n) tap_state = TLR;
        else if (en) tap_state = nxt(tap_state, tms);
    endtask

    task automatic s(input logic tms);
        logic t;
        step(tms, 1'b0, 1'b1, 1'b1, t);
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [3:0] o);
        s(1); s(1); s(0); s(0);
        for (int i = 0; i < 4; i++) step(i == 3, v[i], 1'b1, 1'b1, o[i]);
        s(1); s(0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, input int stall,
                           output logic [31:0] dout, output int oe);
        logic t;
        dout = '0; oe = 0;
        oe += tdo_oe; s(1);
        oe += tdo_oe; s(0);
        oe += tdo_oe; s(0);
        for (int i = 0; i < n; i++) begin
            if (i == stall) begin
                repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, t);
                chk("stall_count", {26'b0, shift_count}, stall);
            end
            oe += tdo_oe;
            step(i == n - 1, i < 32 ? din[i] : 1'b0, 1'b1, 1'b1, t);
            if (i < 32) dout[i] = t;
        end
        oe += tdo_oe; s(1);
        oe += tdo_oe; s(0);
    endtask

    initial begin
        logic t, tms;
        logic [3:0] o;
        logic [31:0] w;
        int oe;
        step(1'b0, 1'b0, 1'b1, 1'b0, t);
        step(1'b0, 1'b0, 1'b1, 1'b0, t);
        #1;
        chk("rst_ir", {28'b0, ir_value}, 32'hE);
        chk("rst_count", {26'b0, shift_count}, 32'd0);
        chk("rst_user", {24'b0, user_q}, 32'd0);
        chk("rst_upd", {31'b0, user_update}, 32'd0);
        chk("rst_tdo", {30'b0, tdo, tdo_oe}, 32'd0);
        s(0);
        dr_scan(32, 32'h0, -1, w, oe);
        chk("idcode", w, IDC);
        chk("idcode_oe", oe, 32'd32);
        chk("idcode_count", {26'b0, shift_count}, 32'd32);
        ir_scan(4'hF, o);
        chk("ir_capture", {30'b0, o[1:0]}, 32'b01);
        chk("ir_bypass", {28'b0, ir_value}, 32'hF);
        dr_scan(3, 32'b101, -1, w, oe);
        chk("bypass", {29'b0, w[2:0]}, 32'b010);
        ir_scan(4'h2, o);
        dr_scan(8, 32'hA5, -1, w, oe);
        chk("user_q", {24'b0, user_q}, 32'hA5);
        chk("user_pulse", {31'b0, user_update}, 32'd1);
        s(0);
        chk("user_pulse_end", {31'b0, user_update}, 32'd0);
        dr_scan(8, 32'h3C, -1, w, oe);
        chk("user_readback", {24'b0, w[7:0]}, 32'hA5);
        ir_scan(4'hE, o);
        dr_scan(32, 32'h0, 10, w, oe);
        chk("idcode_stall", w, IDC);
        ir_scan(4'hF, o);
        dr_scan(70, 32'h0, -1, w, oe);
        chk("count_sat", {26'b0, shift_count}, 32'd63);
        ir_scan(4'h2, o);
        s(1); s(0); s(0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, t);
        step(1'b0, 1'b0, 1'b1, 1'b0, t);
        #1;
        chk("midrst_ir", {28'b0, ir_value}, 32'hE);
        chk("midrst_user", {24'b0, user_q}, 32'h0);
        chk("midrst_upd", {31'b0, user_update}, 32'd0);
        chk("midrst_tdo", {31'b0, tdo}, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            tms = (tap_state == SHDR || tap_state == SHIR) ? ($urandom_range(0, 11) == 0)
                                                           : ($urandom_range(0, 2) == 0);
            step(tms, 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 199) != 0, t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
